// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
// Holds the detector state encoding, the default length-field width and a saturating increment.
package seq_detect_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HUNT = 2'd2
   } state_e;

   localparam int MAX_LEN_DEF = 8;
   localparam int LEN_W       = $clog2(MAX_LEN_DEF + 1);

   // Holds at max_val instead of wrapping to zero.
   function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                           input logic [31:0] max_val);
      return (value >= max_val) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Configuration, data and status bundle of the pattern detector.
// The master side drives config and serial data; the slave side (the detector) returns status.
interface seq_detect_param_if #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8
);
   localparam int LEN_BITS = $clog2(MAX_LEN + 1);

   logic                cfg_we;
   logic [LEN_BITS-1:0] cfg_len;
   logic [MAX_LEN-1:0]  cfg_pattern;
   logic                cfg_overlap;
   logic                in_valid;
   logic                x;
   logic                cnt_clr;
   logic                y;
   logic [CNT_W-1:0]    match_cnt;
   logic [LEN_BITS-1:0] fill;

   modport master (
      output cfg_we, cfg_len, cfg_pattern, cfg_overlap, in_valid, x, cnt_clr,
      input  y, match_cnt, fill
   );

   modport slave (
      input  cfg_we, cfg_len, cfg_pattern, cfg_overlap, in_valid, x, cnt_clr,
      output y, match_cnt, fill
   );

endinterface

// File: rtl/seq_detect_sat_cnt.sv
// CNT_W-bit up-counter that sticks at its maximum value.
// A clear wins over an increment requested in the same cycle.
module seq_detect_sat_cnt
   import seq_detect_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   localparam logic [31:0] MAX_VAL = 32'((64'd1 << CNT_W) - 64'd1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = CNT_W'(sat_inc(32'(cnt_q), MAX_VAL));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Serial bit-stream detector for a runtime-programmable pattern of 1..MAX_LEN bits,
// overlapping or not, with a registered Moore match pulse and a saturating match counter.
module seq_detect_param
   import seq_detect_pkg::*;
#(
   parameter int                 MAX_LEN     = 8,
   parameter int                 CNT_W       = 8,
   parameter int                 DEF_LEN     = 3,
   parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(5)
) (
   input logic               clk,
   input logic               rst_n,
   seq_detect_param_if.slave bus
);

   localparam int LEN_BITS = $clog2(MAX_LEN + 1);

   typedef logic [LEN_BITS-1:0] len_t;

   localparam len_t MAX_LEN_L = len_t'(MAX_LEN);
   localparam len_t DEF_LEN_L = len_t'(DEF_LEN);

   state_e             state_q, state_d;
   len_t               len_q, len_d;
   len_t               fill_q, fill_d;
   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic               ovl_q, ovl_d;
   logic               y_q, y_d;

   len_t               fill_inc;
   logic [MAX_LEN-1:0] hist_shift;
   logic [MAX_LEN-1:0] len_mask;
   logic               match;

   // Only the low len bits of history and pattern take part in the compare.
   always_comb begin
      len_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (i < int'(len_q));
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d    = state_q;
      len_d      = len_q;
      pat_d      = pat_q;
      ovl_d      = ovl_q;
      hist_d     = hist_q;
      fill_d     = fill_q;
      y_d        = 1'b0;
      match      = 1'b0;
      hist_shift = {hist_q[MAX_LEN-2:0], bus.x};
      fill_inc   = (fill_q >= len_q) ? len_q : fill_q + len_t'(1);

      if (bus.cfg_we) begin
         // A config write restarts the hunt; a data bit arriving with it is dropped.
         len_d   = (bus.cfg_len > MAX_LEN_L) ? MAX_LEN_L : bus.cfg_len;
         pat_d   = bus.cfg_pattern;
         ovl_d   = bus.cfg_overlap;
         hist_d  = '0;
         fill_d  = '0;
         state_d = (len_d == '0) ? IDLE : FILL;
      end else if (bus.in_valid && (state_q != IDLE)) begin
         hist_d  = hist_shift;
         match   = (fill_inc == len_q) && (((hist_shift ^ pat_q) & len_mask) == '0);
         fill_d  = (match && !ovl_q) ? '0 : fill_inc;
         y_d     = match;
         state_d = (fill_d == len_q) ? HUNT : FILL;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= (DEF_LEN == 0) ? IDLE : FILL;
         len_q   <= DEF_LEN_L;
         pat_q   <= DEF_PATTERN;
         ovl_q   <= 1'b0;
         hist_q  <= '0;
         fill_q  <= '0;
         y_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         len_q   <= len_d;
         pat_q   <= pat_d;
         ovl_q   <= ovl_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         y_q     <= y_d;
      end
   end

   seq_detect_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (bus.cnt_clr),
      .inc_i (match),
      .cnt_o (bus.match_cnt)
   );

   assign bus.y    = y_q;
   assign bus.fill = fill_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: a queue-based reference model checked every cycle,
// plus literal pulse positions and counts per scenario.
module tb_seq_detect_param;

   localparam int MAX_LEN = 8;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk;
   logic rst_n;

   seq_detect_param_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

   seq_detect_param #(
      .MAX_LEN     (MAX_LEN),
      .CNT_W       (CNT_W),
      .DEF_LEN     (3),
      .DEF_PATTERN (8'b0000_0101)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: the bits received since the last restart, newest at the back.
   bit         q[$];
   int         m_len;
   logic [7:0] m_pat;
   bit         m_ovl;
   bit         m_y;
   int         m_cnt;

   // Per-scenario pulse log, indexed by how many valid bits had been sent.
   int          bit_idx;
   int          pulses;
   logic [31:0] mask;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic void model_reset();
      q.delete();
      m_len = 3;
      m_pat = 8'b101;
      m_ovl = 1'b0;
      m_y   = 1'b0;
      m_cnt = 0;
   endfunction

   function automatic void model_step(input bit we, input int len, input logic [7:0] pat,
                                      input bit ovl, input bit v, input bit xb, input bit clr);
      bit hit;
      hit = 1'b0;
      m_y = 1'b0;
      if (we) begin
         m_len = (len > MAX_LEN) ? MAX_LEN : len;
         m_pat = pat;
         m_ovl = ovl;
         q.delete();
      end else if (v && m_len > 0) begin
         q.push_back(xb);
         if (q.size() > m_len) void'(q.pop_front());
         if (q.size() == m_len) begin
            hit = 1'b1;
            for (int i = 0; i < m_len; i++)
               if (q[i] != m_pat[m_len-1-i]) hit = 1'b0;
         end
         if (hit) begin
            m_y = 1'b1;
            if (!m_ovl) q.delete();
         end
      end
      if (clr) m_cnt = 0;
      else if (hit && m_cnt < CNT_MAX) m_cnt++;
   endfunction

   task automatic cycle(input bit we, input int len, input logic [7:0] pat, input bit ovl,
                        input bit v, input bit xb, input bit clr);
      bus.cfg_we      = we;
      bus.cfg_len     = 4'(len);
      bus.cfg_pattern = pat;
      bus.cfg_overlap = ovl;
      bus.in_valid    = v;
      bus.x           = xb;
      bus.cnt_clr     = clr;
      @(posedge clk);
      model_step(we, len, pat, ovl, v, xb, clr);
      @(negedge clk);
      if (v && !we) bit_idx++;
      check("y", 32'(bus.y), 32'(m_y));
      check("match_cnt", 32'(bus.match_cnt), 32'(m_cnt));
      check("fill", 32'(bus.fill), 32'(q.size()));
      if (bus.y === 1'b1) begin
         pulses++;
         mask |= 32'd1 << bit_idx;
      end
   endtask

   // Bits go out MSB first; each valid bit is followed by `gap` idle cycles.
   task automatic send_bits(input logic [31:0] bits, input int n, input int gap);
      for (int i = n - 1; i >= 0; i--) begin
         cycle(1'b0, 0, 8'h00, 1'b0, 1'b1, bits[i], 1'b0);
         repeat (gap) cycle(1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      end
   endtask

   // The config cycle always carries a valid data bit, which must be dropped.
   task automatic cfg(input int len, input logic [7:0] pat, input bit ovl, input bit xb);
      cycle(1'b1, len, pat, ovl, 1'b1, xb, 1'b1);
   endtask

   task automatic seg_start();
      bit_idx = 0;
      pulses  = 0;
      mask    = '0;
   endtask

   task automatic seg_end(input string name, input int exp_pulses, input logic [31:0] exp_mask,
                          input int exp_cnt);
      check({name, "_pulses"}, 32'(pulses), 32'(exp_pulses));
      check({name, "_pulse_pos"}, mask, exp_mask);
      check({name, "_cnt"}, 32'(bus.match_cnt), 32'(exp_cnt));
   endtask

   // Reset lands between clock edges; outputs must clear without waiting for a clock.
   task automatic async_reset(input string name);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check({name, "_y"}, 32'(bus.y), 32'd0);
      check({name, "_fill"}, 32'(bus.fill), 32'd0);
      check({name, "_cnt"}, 32'(bus.match_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n           = 1'b1;
      bus.cfg_we      = 1'b0;
      bus.cfg_len     = '0;
      bus.cfg_pattern = '0;
      bus.cfg_overlap = 1'b0;
      bus.in_valid    = 1'b0;
      bus.x           = 1'b0;
      bus.cnt_clr     = 1'b0;
      model_reset();
      #1;
      async_reset("reset");

      // Default "101", non-overlapping: one pulse after bit 3, none after bit 5.
      seg_start();
      send_bits(32'b10101, 5, 0);
      seg_end("nonovl", 1, 32'h0000_0008, 1);

      // Same stream, overlapping: pulses after bits 3 and 5.
      cfg(3, 8'b101, 1'b1, 1'b1);
      seg_start();
      send_bits(32'b10101, 5, 0);
      seg_end("ovl", 2, 32'h0000_0028, 2);

      // 1101 non-overlapping; counting the dropped config bit would give a hit at bit 3.
      cfg(4, 8'b1101, 1'b0, 1'b1);
      seg_start();
      send_bits(32'b10_1110_1101, 10, 0);
      seg_end("len4", 1, 32'h0000_0080, 1);

      // 1101 overlapping on 1101101: pulses after bits 4 and 7.
      cfg(4, 8'b1101, 1'b1, 1'b1);
      seg_start();
      send_bits(32'b110_1101, 7, 0);
      seg_end("len4_ovl", 2, 32'h0000_0090, 2);

      // Three idle cycles after every bit: one pulse right after the last valid bit.
      cfg(3, 8'b101, 1'b0, 1'b0);
      seg_start();
      send_bits(32'b101, 3, 3);
      seg_end("gaps", 1, 32'h0000_0008, 1);

      // Six ones on pattern 11, overlapping: five matches, counter sticks at 3.
      cfg(2, 8'b11, 1'b1, 1'b1);
      seg_start();
      send_bits(32'b11_1111, 6, 0);
      seg_end("sat", 5, 32'h0000_007C, 3);
      cycle(1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
      check("clr_vs_match_y", 32'(bus.y), 32'd1);
      check("clr_vs_match_cnt", 32'(bus.match_cnt), 32'd0);

      // Length 15 clamps to 8.
      cfg(15, 8'hA5, 1'b0, 1'b0);
      seg_start();
      send_bits(32'hA5, 8, 0);
      seg_end("clamp", 1, 32'h0000_0100, 1);

      // Length 0: input ignored.
      cfg(0, 8'h00, 1'b0, 1'b0);
      seg_start();
      send_bits(32'b1111, 4, 0);
      seg_end("len0", 0, 32'h0000_0000, 0);
      check("len0_fill", 32'(bus.fill), 32'd0);

      // Length 1, pattern bit 0: every valid 0 matches.
      cfg(1, 8'h00, 1'b0, 1'b0);
      seg_start();
      send_bits(32'b010, 3, 0);
      seg_end("len1", 2, 32'h0000_000A, 2);

      // Reset partway into "101"; no partial match may survive it.
      async_reset("rst_prep");
      seg_start();
      send_bits(32'b10, 2, 0);
      check("pre_rst_fill", 32'(bus.fill), 32'd2);
      async_reset("mid_rst");
      seg_start();
      send_bits(32'b1, 1, 0);
      check("post_rst_single", 32'(pulses), 32'd0);
      send_bits(32'b101, 3, 0);
      seg_end("post_rst", 1, 32'h0000_0010, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
